// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter
// Shares one single-ported memory bus between the OTTER fetch stage (IF) and
// the data-memory stage (MEM). MEM has priority so older instructions are
// never blocked. Every grant is bounded by TIMEOUT_CYC cycles so that a dead
// slave cannot hang the pipeline. An aborted transaction completes with a NOP
// (IF) or zero (DM) and a timeout pulse.
// Optional feature: define OTTER_ARB_FAIR_EN to let IF through after
// MAX_DM_STREAK consecutive DM grants that IF had to wait on.
module otter_mem_arbiter #(
    parameter int TIMEOUT_CYC   = 255,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic        CLK,
    input  logic        RST,
    // fetch side
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    // data side
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [1:0]  dm_size,
    input  logic        dm_sign,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_stall,
    // memory bus
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [1:0]  bus_size,
    output logic        bus_sign,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        timeout
);

    // Counter is wide enough to hold TIMEOUT_CYC, and stops at TIMEOUT_CYC-1.
    localparam int               CNT_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state;
    logic             last_dm;   // side of the current/last grant: 1 = DM
    logic [CNT_W-1:0] cnt;       // cycles spent in the current grant
    logic             if_turn;   // fairness override: IF wins this IDLE
    logic             pick_dm;
    logic             pick_if;

    // Arbitration decision used only in IDLE.
    assign pick_dm = dm_req & ~if_turn;
    assign pick_if = if_req & ~pick_dm;

    // Stall the pipeline while a request is outstanding.
    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;

`ifdef OTTER_ARB_FAIR_EN
    logic [3:0] streak;

    assign if_turn = if_req & (streak == 4'(MAX_DM_STREAK));

    // Count DM grants that IF sat through; an IF grant or an idle IF clears it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            streak <= '0;
        end else if (state == IDLE) begin
            if (!if_req) begin
                streak <= '0;
            end else if (pick_dm) begin
                streak <= streak + 4'd1;
            end else begin
                streak <= '0;
            end
        end
    end
`else
    logic [3:0] unused_max_dm_streak;

    assign if_turn              = 1'b0;
    assign unused_max_dm_streak = 4'(MAX_DM_STREAK);
`endif

    // Word-aligned fetch: the byte offset bits play no part in the bus address.
    logic [1:0] unused_if_addr_lo;
    assign unused_if_addr_lo = if_addr[1:0];

    // Arbitration FSM: latch a request onto the bus, wait for ack or timeout,
    // then spend exactly one cycle signalling completion.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments everywhere in clocked logic, so each
        // register sees pre-edge values of the others regardless of order.
        if (RST) begin
            // NOTE: the datapath registers (bus_*, *_rdata) are reset along
            // with the control state so every output reads 0 out of reset.
            state     <= IDLE;
            last_dm   <= 1'b0;
            cnt       <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_size  <= '0;
            bus_sign  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pick_dm) begin
                        state     <= GNT_DM;
                        last_dm   <= 1'b1;
                        bus_req   <= 1'b1;
                        bus_we    <= dm_we;
                        bus_addr  <= dm_addr;
                        bus_wdata <= dm_wdata;
                        bus_size  <= dm_size;
                        bus_sign  <= dm_sign;
                    end else if (pick_if) begin
                        state     <= GNT_IF;
                        last_dm   <= 1'b0;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_addr  <= {if_addr[31:2], 2'b00};
                        bus_wdata <= '0;
                        bus_size  <= 2'b10;
                        bus_sign  <= 1'b0;
                    end
                end
                GNT_IF, GNT_DM: begin
                    if (bus_ack || cnt == CNT_LAST) begin
                        state   <= RESP;
                        bus_req <= 1'b0;
                        cnt     <= '0;
                        timeout <= ~bus_ack;
                        if (last_dm) begin
                            dm_done  <= 1'b1;
                            dm_rdata <= (bus_ack && !bus_we) ? bus_rdata : 32'h0;
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= bus_ack ? bus_rdata : NOP_INSTR;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    // Requests are ignored here so a still-high req is not re-granted.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// tb_otter_mem_arbiter
// Randomized transaction-level bench for otter_mem_arbiter. Each scenario is
// one or two requests issued from IDLE; the expected timeline (grant windows,
// done/timeout cycles, returned data) is computed from the arbitration and
// latency rules, and the slave ack is driven open-loop from that timeline.
// Define OTTER_ARB_FAIR_EN to also exercise the fairness grant order.
module tb_otter_mem_arbiter;

    localparam int          TO     = 8;
    localparam int          STREAK = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [1:0]  dm_size;
    logic        dm_sign;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [1:0]  bus_size;
    logic        bus_sign;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        timeout;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_dm_rdata;

    typedef struct {
        bit          en;
        bit          dm;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        logic [1:0]  size;
        bit          sign;
        int          len;    // cycles bus_req stays high for this grant
        bit          to;     // slave never acks: aborted after TO cycles
        logic [31:0] rdata;
        int          drop;   // last cycle the requester holds req (if early)
    } txn_t;

    always #5 CLK = ~CLK;

    otter_mem_arbiter #(
        .TIMEOUT_CYC  (TO),
        .MAX_DM_STREAK(STREAK)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .if_stall (if_stall),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_size  (dm_size),
        .dm_sign  (dm_sign),
        .dm_rdata (dm_rdata),
        .dm_done  (dm_done),
        .dm_stall (dm_stall),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_size (bus_size),
        .bus_sign (bus_sign),
        .bus_ack  (bus_ack),
        .bus_rdata(bus_rdata),
        .timeout  (timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic txn_t mk_if(input logic [31:0] addr, input int len, input bit to,
                                   input logic [31:0] rdata);
        txn_t t;
        t.en = 1'b1;  t.dm = 1'b0;  t.addr = addr;  t.we = 1'b0;  t.wdata = 32'h0;
        t.size = 2'b10;  t.sign = 1'b0;  t.len = len;  t.to = to;  t.rdata = rdata;
        t.drop = 100;
        return t;
    endfunction

    function automatic txn_t mk_dm(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [1:0] size, input bit sign, input int len,
                                   input bit to, input logic [31:0] rdata);
        txn_t t;
        t.en = 1'b1;  t.dm = 1'b1;  t.addr = addr;  t.we = we;  t.wdata = wdata;
        t.size = size;  t.sign = sign;  t.len = len;  t.to = to;  t.rdata = rdata;
        t.drop = 100;
        return t;
    endfunction

    // An absent request; its fields still drive the inputs as noise.
    function automatic txn_t none(input bit is_dm);
        txn_t t;
        t = mk_dm(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1, 1'b0, $urandom);
        t.en = 1'b0;
        t.dm = is_dm;
        return t;
    endfunction

    function automatic txn_t rand_txn(input bit is_dm);
        txn_t t;
        int   r;
        int   len;
        bit   to;
        r = $urandom_range(0, 9);
        if (r < 6) begin
            len = $urandom_range(1, 4);  to = 1'b0;
        end else if (r < 8) begin
            len = TO;  to = 1'b0;        // ack in the very last allowed cycle
        end else begin
            len = TO;  to = 1'b1;        // slave never answers
        end
        if (is_dm) begin
            t = mk_dm(1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom_range(0, 2)),
                      1'($urandom_range(0, 1)), len, to, $urandom);
        end else begin
            t = mk_if($urandom, len, to, $urandom);
        end
        t.drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : 100;
        return t;
    endfunction

    // Value the requester must see at its done.
    function automatic logic [31:0] resp_data(input txn_t t);
        if (t.to) return t.dm ? 32'h0 : NOP;
        if (t.dm && t.we) return 32'h0;
        return t.rdata;
    endfunction

    task automatic check_bus(input txn_t t);
        check("bus_we", bus_we, t.we);
        check("bus_addr", bus_addr, t.dm ? t.addr : {t.addr[31:2], 2'b00});
        check("bus_size", bus_size, t.size);
        check("bus_sign", bus_sign, t.sign);
        if (t.dm) check("bus_wdata", bus_wdata, t.wdata);
    endtask

    task automatic check_quiet();
        check("idle_bus_req", bus_req, 1'b0);
        check("idle_if_done", if_done, 1'b0);
        check("idle_dm_done", dm_done, 1'b0);
        check("idle_timeout", timeout, 1'b0);
        check("idle_if_rdata", if_rdata, exp_if_rdata);
        check("idle_dm_rdata", dm_rdata, exp_dm_rdata);
    endtask

    task automatic check_all_zero();
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_bus_we", bus_we, 1'b0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_bus_size", bus_size, 2'b00);
        check("rst_bus_sign", bus_sign, 1'b0);
        check("rst_if_done", if_done, 1'b0);
        check("rst_dm_done", dm_done, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_dm_rdata", dm_rdata, 32'h0);
    endtask

    // Called at a negedge inside a RESP or IDLE cycle; returns at the negedge of
    // the last RESP, so the next cycle is IDLE again.
    task automatic run_scenario(input txn_t ti, input txn_t td, input int gap);
        txn_t t1, t2;
        bit   two, in1, in2, ack;
        int   s1, e1, r1, s2, e2, r2, last;
        int   done_if, done_dm, hold_if, hold_dm;

        two = ti.en && td.en;
        if (td.en) begin t1 = td; t2 = ti; end
        else       begin t1 = ti; t2 = td; end
        // Request seen in IDLE at cycle 0; bus_req from cycle 1 for len cycles,
        // one RESP cycle, one IDLE cycle, then the waiting side's grant.
        s1 = 1;       e1 = t1.len;          r1 = e1 + 1;
        s2 = r1 + 2;  e2 = s2 + t2.len - 1; r2 = e2 + 1;
        last    = two ? r2 : r1;
        done_if = ti.en ? (two ? r2 : r1) : -1;
        done_dm = td.en ? r1 : -1;
        hold_if = (two || ti.drop > done_if) ? done_if : ti.drop;
        hold_dm = (td.drop > done_dm) ? done_dm : td.drop;

        for (int g = 0; g < gap; g++) begin
            @(negedge CLK);
            check_quiet();
            if_req    = 1'b0;
            dm_req    = 1'b0;
            bus_ack   = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
        end

        @(negedge CLK);
        check_quiet();
        if_req    = ti.en;
        if_addr   = ti.addr;
        dm_req    = td.en;
        dm_we     = td.we;
        dm_addr   = td.addr;
        dm_wdata  = td.wdata;
        dm_size   = td.size;
        dm_sign   = td.sign;
        bus_ack   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        #1;
        check("if_stall", if_stall, ti.en);
        check("dm_stall", dm_stall, td.en);

        for (int c = 1; c <= last; c++) begin
            @(negedge CLK);
            in1 = (c >= s1) && (c <= e1);
            in2 = two && (c >= s2) && (c <= e2);
            check("bus_req", bus_req, in1 || in2);
            if (in1) check_bus(t1);
            else if (in2) check_bus(t2);
            if (c == done_if) exp_if_rdata = resp_data(ti);
            if (c == done_dm) exp_dm_rdata = resp_data(td);
            check("if_done", if_done, c == done_if);
            check("dm_done", dm_done, c == done_dm);
            check("timeout", timeout, (c == r1 && t1.to) || (two && c == r2 && t2.to));
            check("if_rdata", if_rdata, exp_if_rdata);
            check("dm_rdata", dm_rdata, exp_dm_rdata);

            if_req = ti.en && (c <= hold_if);
            dm_req = td.en && (c <= hold_dm);
            if (in1)      ack = (c == e1) && !t1.to;
            else if (in2) ack = (c == e2) && !t2.to;
            else          ack = 1'($urandom_range(0, 1));   // ignored outside a grant
            bus_ack   = ack;
            bus_rdata = (ack && (in1 || in2)) ? (in1 ? t1.rdata : t2.rdata) : $urandom;
            #1;
            check("if_stall", if_stall, if_req && (c != done_if));
            check("dm_stall", dm_stall, dm_req && (c != done_dm));
        end
    endtask

    // Reset lands while a store holds the bus: outputs clear, no done pulses.
    task automatic reset_mid_grant();
        @(negedge CLK);
        if_req   = 1'b0;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h8000_1234;
        dm_wdata = 32'hDEAD_BEEF;
        dm_size  = 2'b01;
        dm_sign  = 1'b1;
        bus_ack  = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge CLK);
            check("rmg_bus_req", bus_req, 1'b1);
            check("rmg_bus_addr", bus_addr, 32'h8000_1234);
        end
        RST = 1'b1;
        @(negedge CLK);
        check_all_zero();
        exp_if_rdata = 32'h0;
        exp_dm_rdata = 32'h0;
        RST    = 1'b0;
        dm_req = 1'b0;
        @(negedge CLK);
        check("rmg_no_done", dm_done, 1'b0);
        check("rmg_idle_bus_req", bus_req, 1'b0);
        // The requester reissues the same store.
        run_scenario(none(1'b0), mk_dm(1'b1, 32'h8000_1234, 32'hDEAD_BEEF, 2'b01, 1'b1, 2, 1'b0,
                                       $urandom), 0);
    endtask

`ifdef OTTER_ARB_FAIR_EN
    // Both sides request nonstop; IF must get every (STREAK+1)-th grant.
    task automatic fair_test();
        bit          prev;
        int          grants;
        logic [31:0] want;
        @(negedge CLK);
        if_req  = 1'b1;  if_addr = 32'h0000_0400;
        dm_req  = 1'b1;  dm_we   = 1'b0;  dm_addr = 32'h0000_3000;
        dm_size = 2'b10; dm_sign = 1'b0;  bus_ack = 1'b0;
        prev   = 1'b0;
        grants = 0;
        for (int cyc = 0; cyc < 100 && grants < 6; cyc++) begin
            @(negedge CLK);
            if (bus_req && !prev) begin
                want = ((grants % (STREAK + 1)) == STREAK) ? 32'h0000_0400 : 32'h0000_3000;
                check("fair_order", bus_addr, want);
                grants++;
            end
            prev      = bus_req;
            bus_ack   = bus_req;
            bus_rdata = $urandom;
        end
        check("fair_grants", grants, 6);
        if_req  = 1'b0;
        dm_req  = 1'b0;
        bus_ack = 1'b0;
        repeat (4) @(negedge CLK);
    endtask
`endif

    initial begin
        RST       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        dm_size   = '0;
        dm_sign   = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        exp_if_rdata = 32'h0;
        exp_dm_rdata = 32'h0;

        repeat (3) @(negedge CLK);
        check_all_zero();
        RST = 1'b0;

        // Fetch with ack two cycles after bus_req rises.
        run_scenario(mk_if(32'h0000_0100, 3, 1'b0, 32'h0050_0093), none(1'b1), 0);
        // Simultaneous requests: DM first, then IF.
        run_scenario(mk_if(32'h0000_0206, 2, 1'b0, $urandom),
                     mk_dm(1'b0, 32'h0000_2000, $urandom, 2'b10, 1'b0, 2, 1'b0, $urandom), 1);
        // Byte store.
        run_scenario(none(1'b0),
                     mk_dm(1'b1, 32'h1100_0000, 32'hA5A5_A5A5, 2'b00, 1'b0, 3, 1'b0, $urandom), 0);
        // Dead slave on each side.
        run_scenario(mk_if($urandom, TO, 1'b1, $urandom), none(1'b1), 0);
        run_scenario(none(1'b0), mk_dm(1'b0, $urandom, $urandom, 2'b10, 1'b0, TO, 1'b1, $urandom), 2);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 2))
                0:       run_scenario(rand_txn(1'b0), none(1'b1), $urandom_range(0, 2));
                1:       run_scenario(none(1'b0), rand_txn(1'b1), $urandom_range(0, 2));
                default: run_scenario(rand_txn(1'b0), rand_txn(1'b1), $urandom_range(0, 2));
            endcase
        end

        reset_mid_grant();

        for (int i = 0; i < 10; i++) begin
            run_scenario(rand_txn(1'b0), rand_txn(1'b1), $urandom_range(0, 2));
        end

`ifdef OTTER_ARB_FAIR_EN
        fair_test();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
